// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I pipeline types: ALU op codes and CDB payload
package rv32i_types;

    localparam int TAG_W = 4;

    typedef enum logic [3:0] {
        alu_add  = 4'd0,
        alu_sll  = 4'd1,
        alu_sra  = 4'd2,
        alu_sub  = 4'd3,
        alu_xor  = 4'd4,
        alu_srl  = 4'd5,
        alu_or   = 4'd6,
        alu_and  = 4'd7,
        alu_slt  = 4'd8,
        alu_sltu = 4'd9
    } alu_ops;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } cdb_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational RV32I integer ALU
module alu
    import rv32i_types::*;
(
    input  alu_ops      aluop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] f
);

    always_comb begin
        case (aluop)
            alu_add:  f = a + b;
            alu_sll:  f = a << b[4:0];
            alu_sra:  f = $unsigned($signed(a) >>> b[4:0]);
            alu_sub:  f = a - b;
            alu_xor:  f = a ^ b;
            alu_srl:  f = a >> b[4:0];
            alu_or:   f = a | b;
            alu_and:  f = a & b;
            alu_slt:  f = {31'b0, $signed(a) < $signed(b)};
            alu_sltu: f = {31'b0, a < b};
            default:  f = a + b;
        endcase
    end

endmodule

// File: rtl/alu_issue_arbiter_rr_arbiter.sv
// rtl/alu_issue_arbiter_rr_arbiter.sv - combinational round-robin picker, first request at or after rr_ptr
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    // NUM_REQ is a power of two, so the IDX_W-bit add wraps modulo NUM_REQ
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = rr_ptr + IDX_W'(k);
            if (enable && !any && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// rtl/alu_issue_arbiter.sv - round-robin issue of ready RS entries to the shared ALU, one-deep CDB output stage
module alu_issue_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = rv32i_types::TAG_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  rv32i_types::alu_ops [NUM_REQ-1:0]   req_aluop,
    input  logic [NUM_REQ-1:0][31:0]            req_a,
    input  logic [NUM_REQ-1:0][31:0]            req_b,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]       req_tag,
    output logic [NUM_REQ-1:0]                  req_grant,
    output logic                                cdb_valid,
    input  logic                                cdb_ready,
    output logic [TAG_W-1:0]                    cdb_tag,
    output logic [31:0]                         cdb_data
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic                 accept;
    logic                 any_grant;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant_idx;
    rv32i_types::alu_ops  sel_op;
    logic [31:0]          sel_a;
    logic [31:0]          sel_b;
    logic [TAG_W-1:0]     sel_tag;
    logic [31:0]          alu_f;

    // The output slot is free when empty or being drained this edge
    assign accept = !flush && (!cdb_valid || cdb_ready);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req    (req_valid),
        .enable (accept && !rst),
        .rr_ptr (rr_ptr),
        .grant  (req_grant),
        .idx    (grant_idx),
        .any    (any_grant)
    );

    always_comb begin
        sel_op  = rv32i_types::alu_add;
        sel_a   = '0;
        sel_b   = '0;
        sel_tag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_grant[i]) begin
                sel_op  = req_aluop[i];
                sel_a   = req_a[i];
                sel_b   = req_b[i];
                sel_tag = req_tag[i];
            end
        end
    end

    alu u_alu (
        .aluop (sel_op),
        .a     (sel_a),
        .b     (sel_b),
        .f     (alu_f)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (any_grant) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= sel_tag;
            cdb_data  <= alu_f;
            rr_ptr    <= grant_idx + IDX_W'(1);
        end else if (cdb_valid && cdb_ready) begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb/tb_alu_issue_arbiter.sv - scoreboard bench for alu_issue_arbiter
module tb_alu_issue_arbiter;
    import rv32i_types::*;

    localparam int N  = 4;
    localparam int TW = 4;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [31:0]   data;
    } res_t;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic [N-1:0]           req_valid;
    alu_ops [N-1:0]         req_aluop;
    logic [N-1:0][31:0]     req_a;
    logic [N-1:0][31:0]     req_b;
    logic [N-1:0][TW-1:0]   req_tag;
    logic [N-1:0]           req_grant;
    logic                   cdb_valid;
    logic                   cdb_ready;
    logic [TW-1:0]          cdb_tag;
    logic [31:0]            cdb_data;

    logic          ent_valid [N];
    alu_ops        ent_op    [N];
    logic [31:0]   ent_a     [N];
    logic [31:0]   ent_b     [N];
    logic [31:0]   ent_exp   [N];
    logic [TW-1:0] ent_tag   [N];

    res_t sb[$];
    int   mptr;
    bit   refill;
    int   n_checks;
    int   n_fail;

    alu_issue_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_aluop (req_aluop),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .req_grant (req_grant),
        .cdb_valid (cdb_valid),
        .cdb_ready (cdb_ready),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic expect_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input alu_ops op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        logic [4:0]  sh;
        sh = b[4:0];
        case (op)
            alu_add:  return a + b;
            alu_sub:  return a + ~b + 32'd1;
            alu_sll:  return a << sh;
            alu_srl:  return a >> sh;
            alu_sra:  begin ext = {{32{a[31]}}, a} >> sh; return ext[31:0]; end
            alu_xor:  return a ^ b;
            alu_or:   return a | b;
            alu_and:  return a & b;
            alu_slt:  return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
            alu_sltu: return {31'b0, a < b};
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic set_entry(input int i, input alu_ops op, input logic [31:0] a, input logic [31:0] b,
                             input logic [TW-1:0] tag, input logic [31:0] exp);
        ent_valid[i] = 1'b1;
        ent_op[i]    = op;
        ent_a[i]     = a;
        ent_b[i]     = b;
        ent_tag[i]   = tag;
        ent_exp[i]   = exp;
    endtask

    task automatic rand_entry(input int i);
        alu_ops      op;
        logic [31:0] a;
        logic [31:0] b;
        op = alu_ops'(4'($urandom_range(0, 9)));
        a  = $urandom;
        b  = $urandom;
        set_entry(i, op, a, b, TW'($urandom_range(0, 15)), alu_ref(op, a, b));
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = ent_valid[i];
            req_aluop[i] = ent_op[i];
            req_a[i]     = ent_a[i];
            req_b[i]     = ent_b[i];
            req_tag[i]   = ent_tag[i];
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) ent_valid[i] = 1'b0;
        drive();
    endtask

    // Check one cycle at the falling edge, advance the model, then update requesters after the rising edge
    task automatic cycle();
        int           g;
        logic [N-1:0] eg;
        bit           qv;
        bit           acc;
        res_t         r;
        @(negedge clk);
        qv = (sb.size() != 0);
        expect_eq("cdb_valid", cdb_valid, qv);
        if (qv) begin
            expect_eq("cdb_tag", cdb_tag, sb[0].tag);
            expect_eq("cdb_data", cdb_data, sb[0].data);
        end
        acc = !flush && (!qv || cdb_ready);
        g   = -1;
        eg  = '0;
        if (acc) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && ent_valid[(mptr + k) % N]) g = (mptr + k) % N;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        expect_eq("req_grant", req_grant, eg);
        if (flush) begin
            if (qv) void'(sb.pop_front());
        end else begin
            if (qv && cdb_ready) void'(sb.pop_front());
            if (g >= 0) begin
                r.tag  = ent_tag[g];
                r.data = ent_exp[g];
                sb.push_back(r);
                mptr = (g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        if (g >= 0) begin
            if (refill && $urandom_range(0, 3) != 0) rand_entry(g);
            else ent_valid[g] = 1'b0;
        end
        drive();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        mptr      = 0;
        refill    = 1'b0;
        rst       = 1'b1;
        flush     = 1'b0;
        cdb_ready = 1'b1;
        for (int i = 0; i < N; i++) set_entry(i, alu_add, 32'd0, 32'd0, '0, 32'd0);
        clear_all();
        set_entry(0, alu_add, 32'd5, 32'd7, 4'd3, 32'd12);
        drive();

        #5;
        expect_eq("rst_cdb_valid", cdb_valid, 1'b0);
        expect_eq("rst_cdb_tag", cdb_tag, '0);
        expect_eq("rst_cdb_data", cdb_data, 32'd0);
        expect_eq("rst_req_grant", req_grant, '0);
        @(posedge clk);
        #1 rst = 1'b0;

        // first transaction: 5+7 tag 3
        cycle();
        expect_eq("rr_ptr_first", dut.rr_ptr, 64'd1);
        cycle();

        // all entries valid back to back
        refill = 1'b1;
        for (int i = 0; i < N; i++) rand_entry(i);
        drive();
        repeat (10) cycle();
        refill = 1'b0;
        clear_all();
        cycle();

        // backpressure hold on a subtract result
        set_entry(2, alu_sub, 32'd3, 32'd5, 4'd9, 32'hFFFF_FFFE);
        drive();
        cycle();
        cdb_ready = 1'b0;
        set_entry(0, alu_and, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'd5, 32'h00F0_1234);
        drive();
        repeat (3) cycle();
        expect_eq("stall_data", cdb_data, 32'hFFFF_FFFE);
        expect_eq("stall_tag", cdb_tag, 4'd9);
        cdb_ready = 1'b1;
        cycle();
        cycle();

        // shift and compare corner cases
        set_entry(0, alu_sra, 32'h8000_0000, 32'd4, 4'd1, 32'hF800_0000);
        set_entry(1, alu_sltu, 32'd1, 32'hFFFF_FFFF, 4'd2, 32'd1);
        set_entry(3, alu_slt, 32'd1, 32'hFFFF_FFFF, 4'd4, 32'd0);
        drive();
        repeat (5) cycle();

        // flush of a held result
        set_entry(1, alu_xor, 32'hAAAA_5555, 32'hFFFF_0000, 4'd7, 32'h5555_5555);
        cdb_ready = 1'b0;
        drive();
        cycle();
        cycle();
        set_entry(2, alu_or, 32'h0000_1000, 32'h0000_0001, 4'd8, 32'h0000_1001);
        flush = 1'b1;
        drive();
        cycle();
        expect_eq("flush_rr_ptr", dut.rr_ptr, mptr);
        flush     = 1'b0;
        cdb_ready = 1'b1;
        cycle();
        cycle();
        cycle();

        // asynchronous reset between edges while a result is held
        set_entry(0, alu_add, 32'd100, 32'd23, 4'd6, 32'd123);
        cdb_ready = 1'b0;
        drive();
        cycle();
        expect_eq("pre_rst_valid", cdb_valid, 1'b1);
        clear_all();
        #2 rst = 1'b1;
        #1;
        expect_eq("async_rst_valid", cdb_valid, 1'b0);
        expect_eq("async_rst_tag", cdb_tag, '0);
        expect_eq("async_rst_data", cdb_data, 32'd0);
        expect_eq("async_rst_grant", req_grant, '0);
        #1 rst = 1'b0;
        sb.delete();
        mptr = 0;
        expect_eq("async_rst_rr_ptr", dut.rr_ptr, 64'd0);
        cdb_ready = 1'b1;
        cycle();

        // random traffic with backpressure and occasional flush
        refill = 1'b1;
        for (int i = 0; i < N; i++) rand_entry(i);
        drive();
        repeat (300) begin
            cdb_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < N; i++) begin
                if (!ent_valid[i] && $urandom_range(0, 1) == 1) rand_entry(i);
            end
            drive();
            cycle();
        end
        flush  = 1'b0;
        refill = 1'b0;
        cdb_ready = 1'b1;
        clear_all();
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
